// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO pointer/flag controller.
// Holds the default SRAM address width, the pointer-width helper and the
// encoding of the per-cycle accepted request, which drives the count update.
package fifo_ctrl_pkg;

    localparam int FIFO_DEF_ADDR_WIDTH = 8;

    // Pointers carry one extra wrap bit above the SRAM address bits.
    function automatic int ptrWidth(input int addrWidth);
        return addrWidth + 1;
    endfunction

    // Accepted request this cycle, encoded as {push_ok, pop_ok}.
    typedef enum logic [1:0] {
        REQ_NONE = 2'b00,
        REQ_POP  = 2'b01,
        REQ_PUSH = 2'b10,
        REQ_BOTH = 2'b11
    } fifoReq_e;

endpackage

// File: rtl/fifo_ctrl_if.sv
// User-side handshake bundle of the FIFO controller.
// The master drives push/pop; the slave (fifo_ctrl) returns status, flags and
// the read-valid strobe that qualifies SRAM Dout.
interface fifo_ctrl_if
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_DEF_ADDR_WIDTH
);
    logic                  push;
    logic                  pop;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
    logic                  almost_full;
    logic                  almost_empty;

    modport master (
        output push, pop,
        input  rd_valid, full, empty, count, overflow, underflow,
               almost_full, almost_empty
    );

    modport slave (
        input  push, pop,
        output rd_valid, full, empty, count, overflow, underflow,
               almost_full, almost_empty
    );
endinterface

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: address bits plus one wrap bit, advanced by one
// whenever the increment enable is high. Used once for writes, once for reads.
module fifo_ptr #(
    parameter int PTR_WIDTH = 9
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_inc,
    output logic [PTR_WIDTH-1:0] o_ptr
);
    logic [PTR_WIDTH-1:0] r_ptr;

    // Advance on enable; natural overflow toggles the wrap bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + PTR_WIDTH'(1);
        end
    end

    assign o_ptr = r_ptr;
endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a synchronous FIFO in front of a dual-address
// SRAM. Data never passes through here; only addresses, enables and status.
// Optional almost-full/almost-empty flags are built when FIFO_ALMOST_FLAGS_EN
// is defined; otherwise both flags are tied low.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_DEF_ADDR_WIDTH,
    parameter int AF_THRESH  = 2**ADDR_WIDTH - 4,
    parameter int AE_THRESH  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    fifo_ctrl_if.slave            io_user,
    output logic                  o_sram_wr_en,
    output logic                  o_sram_rd_en,
    output logic                  o_sram_cs,
    output logic [ADDR_WIDTH-1:0] o_sram_waddr,
    output logic [ADDR_WIDTH-1:0] o_sram_raddr
);
    localparam int PTR_W = ptrWidth(ADDR_WIDTH);

    // Thresholds must be representable occupancies.
    if (AF_THRESH < 0 || AF_THRESH > 2**ADDR_WIDTH ||
        AE_THRESH < 0 || AE_THRESH > 2**ADDR_WIDTH) begin : gBadThresh
        $error("fifo_ctrl: almost-flag threshold outside 0..depth");
    end

    logic [PTR_W-1:0] w_wptr;
    logic [PTR_W-1:0] w_rptr;
    logic             w_full;
    logic             w_empty;
    logic             w_pushOk;
    logic             w_popOk;
    fifoReq_e         w_req;
    logic [PTR_W-1:0] w_countNext;
    logic [PTR_W-1:0] r_count;
    logic             r_rdValid;
    logic             r_overflow;
    logic             r_underflow;

    fifo_ptr #(.PTR_WIDTH(PTR_W)) uWritePtr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_pushOk),
        .o_ptr   (w_wptr)
    );

    fifo_ptr #(.PTR_WIDTH(PTR_W)) uReadPtr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_popOk),
        .o_ptr   (w_rptr)
    );

    // Flags come straight from the registered pointers, so push/pop never
    // reach them combinationally. A pop frees a slot for a same-cycle push.
    assign w_full   = (w_wptr[ADDR_WIDTH-1:0] == w_rptr[ADDR_WIDTH-1:0]) &&
                      (w_wptr[ADDR_WIDTH] != w_rptr[ADDR_WIDTH]);
    assign w_empty  = (w_wptr == w_rptr);
    assign w_popOk  = io_user.pop & ~w_empty;
    assign w_pushOk = io_user.push & (~w_full | w_popOk);
    assign w_req    = fifoReq_e'({w_pushOk, w_popOk});

    // The SRAM keeps Dout driven through the rd_valid cycle, so rd_en spans
    // both the request cycle and the cycle the data is presented.
    assign o_sram_wr_en = w_pushOk;
    assign o_sram_rd_en = w_popOk | r_rdValid;
    assign o_sram_cs    = o_sram_wr_en | o_sram_rd_en;
    assign o_sram_waddr = w_wptr[ADDR_WIDTH-1:0];
    assign o_sram_raddr = w_rptr[ADDR_WIDTH-1:0];

    // Next occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        w_countNext = r_count;
        case (w_req)
            REQ_PUSH: w_countNext = r_count + PTR_W'(1);
            REQ_POP:  w_countNext = r_count - PTR_W'(1);
            default:  w_countNext = r_count;
        endcase
    end

    // Occupancy, read-valid strobe and rejection pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count     <= '0;
            r_rdValid   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_countNext;
            r_rdValid   <= w_popOk;
            r_overflow  <= io_user.push & ~w_pushOk;
            r_underflow <= io_user.pop & ~w_popOk;
        end
    end

    assign io_user.rd_valid  = r_rdValid;
    assign io_user.full      = w_full;
    assign io_user.empty     = w_empty;
    assign io_user.count     = r_count;
    assign io_user.overflow  = r_overflow;
    assign io_user.underflow = r_underflow;

`ifdef FIFO_ALMOST_FLAGS_EN
    logic r_almostFull;
    logic r_almostEmpty;

    // Almost flags track the occupancy being loaded on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_almostFull  <= 1'b0;
            r_almostEmpty <= 1'b1;
        end else begin
            r_almostFull  <= (w_countNext >= PTR_W'(AF_THRESH));
            r_almostEmpty <= (w_countNext <= PTR_W'(AE_THRESH));
        end
    end

    assign io_user.almost_full  = r_almostFull;
    assign io_user.almost_empty = r_almostEmpty;
`else
    assign io_user.almost_full  = 1'b0;
    assign io_user.almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Testbench for fifo_ctrl with a small behavioural SRAM (depth 8).
// The driver keeps a queue model of FIFO contents; accepted pops push their
// expected word to a scoreboard that a negedge monitor drains on rd_valid.
module tb_fifo_ctrl;

    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fifo_ctrl_if #(.ADDR_WIDTH(AW)) fifoBus ();

    logic          sramWrEn;
    logic          sramRdEn;
    logic          sramCs;
    logic [AW-1:0] sramWaddr;
    logic [AW-1:0] sramRaddr;
    logic [7:0]    din;
    logic [7:0]    sramQ;
    logic [7:0]    mem [DEPTH];
    wire  [7:0]    dout;

    fifo_ctrl #(
        .ADDR_WIDTH (AW),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .io_user      (fifoBus),
        .o_sram_wr_en (sramWrEn),
        .o_sram_rd_en (sramRdEn),
        .o_sram_cs    (sramCs),
        .o_sram_waddr (sramWaddr),
        .o_sram_raddr (sramRaddr)
    );

    // Synchronous SRAM: registered read, read-before-write on the same address.
    always @(posedge clk) begin
        if (sramCs && sramRdEn) sramQ <= mem[sramRaddr];
        if (sramCs && sramWrEn) mem[sramWaddr] <= din;
    end

    assign dout = (sramCs && sramRdEn) ? sramQ : 8'hzz;

    logic [7:0] modelQ [$];
    logic [7:0] expQ [$];
    int         wrCount;
    int         rdCount;
    bit         expRdValid;
    bit         expOvf;
    bit         expUnf;
    int         checks = 0;
    int         errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic resetModel();
        modelQ.delete();
        expQ.delete();
        wrCount    = 0;
        rdCount    = 0;
        expRdValid = 1'b0;
        expOvf     = 1'b0;
        expUnf     = 1'b0;
    endtask

    task automatic checkStatus();
        int n;
        n = modelQ.size();
        checkOutput("count",     fifoBus.count,     n);
        checkOutput("full",      fifoBus.full,      (n == DEPTH));
        checkOutput("empty",     fifoBus.empty,     (n == 0));
        checkOutput("rd_valid",  fifoBus.rd_valid,  expRdValid);
        checkOutput("overflow",  fifoBus.overflow,  expOvf);
        checkOutput("underflow", fifoBus.underflow, expUnf);
`ifdef FIFO_ALMOST_FLAGS_EN
        checkOutput("almost_full",  fifoBus.almost_full,  (n >= AF));
        checkOutput("almost_empty", fifoBus.almost_empty, (n <= AE));
`else
        checkOutput("almost_full",  fifoBus.almost_full,  0);
        checkOutput("almost_empty", fifoBus.almost_empty, 0);
`endif
    endtask

    // One clock cycle of stimulus, starting just after a rising edge.
    task automatic applyStimulus(input bit doPush, input bit doPop, input logic [7:0] data);
        bit popOk;
        bit pushOk;
        popOk  = doPop && (modelQ.size() > 0);
        pushOk = doPush && ((modelQ.size() < DEPTH) || popOk);
        fifoBus.push = doPush;
        fifoBus.pop  = doPop;
        din          = data;
        #1;
        checkOutput("sram_wr_en", sramWrEn,  pushOk);
        checkOutput("sram_rd_en", sramRdEn,  (popOk || expRdValid));
        checkOutput("sram_cs",    sramCs,    (pushOk || popOk || expRdValid));
        checkOutput("sram_waddr", sramWaddr, wrCount % DEPTH);
        checkOutput("sram_raddr", sramRaddr, rdCount % DEPTH);
        if (popOk) begin
            expQ.push_back(modelQ.pop_front());
            rdCount++;
        end
        if (pushOk) begin
            modelQ.push_back(data);
            wrCount++;
        end
        expRdValid = popOk;
        expOvf     = doPush && !pushOk;
        expUnf     = doPop && !popOk;
        @(posedge clk);
        #1;
        fifoBus.push = 1'b0;
        fifoBus.pop  = 1'b0;
        checkStatus();
    endtask

    // Scoreboard monitor: every presented read word must match the oldest pending one.
    always @(negedge clk) begin
        if (rst_n && fifoBus.rd_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("rd_valid without pending pop", fifoBus.rd_valid, 0);
            end else begin
                checkOutput("read data", dout, expQ.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pushPct;
        fifoBus.push = 1'b0;
        fifoBus.pop  = 1'b0;
        din          = 8'h00;
        resetModel();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("[TB] reset and idle");
        checkStatus();
        checkOutput("idle sram_cs", sramCs, 0);

        $display("[TB] fill to full, then overflow");
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b0, 8'(i * 8'h11));
        applyStimulus(1'b1, 1'b0, 8'h99);

        $display("[TB] drain, then underflow");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);

        $display("[TB] push and pop together while empty");
        applyStimulus(1'b1, 1'b1, 8'h5A);
        applyStimulus(1'b0, 1'b1, 8'h00);

        $display("[TB] push plus pop while full");
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b0, 8'(i * 8'h11));
        applyStimulus(1'b1, 1'b1, 8'h99);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);

        $display("[TB] interleaved pairs across the wrap");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, 8'($urandom));
            applyStimulus(1'b0, 1'b1, 8'h00);
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            pushPct = (i < 150) ? 70 : 30;
            applyStimulus($urandom_range(0, 99) < pushPct,
                          $urandom_range(0, 99) < 50, 8'($urandom));
        end

        $display("[TB] reset with data pending");
        applyStimulus(1'b0, 1'b0, 8'h00);
        while (modelQ.size() > 0) applyStimulus(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 8'($urandom));
        applyStimulus(1'b0, 1'b1, 8'h00);
        rst_n = 1'b0;
        resetModel();
        #1;
        checkStatus();
        checkOutput("reset sram_cs", sramCs, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] traffic after reset");
        for (int i = 0; i < 40; i++) begin
            applyStimulus($urandom_range(0, 99) < 60,
                          $urandom_range(0, 99) < 50, 8'($urandom));
        end
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("scoreboard drained", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
